// File: rtl/ddr3_burst_arbiter.sv
// Write/read burst arbiter for a DDR3 ring buffer: one outstanding burst, alternating ties.
// Optional completion watchdog enabled by defining ARB_TIMEOUT_EN.
module ddr3_burst_arbiter #(
    parameter int                ADDR_W      = 28,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int                BURST_INC   = 8,
    parameter int                RING_BURSTS = 1024,
    parameter int                CNT_W       = 11,
    parameter int                RD_START_TH = 512,
    parameter int                TIMEOUT_CYC = 1024
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              wr_req,
    input  logic              rd_req,
    input  logic              flush,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic              cmd_rw,
    output logic [ADDR_W-1:0] cmd_addr,
    input  logic              done,
    output logic              wr_ack,
    output logic              rd_ack,
    output logic [CNT_W-1:0]  fill,
    output logic              full,
    output logic              empty,
    output logic              play_en,
    output logic              timeout_err,
    output logic [1:0]        dbg_state_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CMD  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    localparam logic [ADDR_W-1:0] INC       = ADDR_W'(BURST_INC);
    localparam logic [ADDR_W-1:0] LAST_ADDR = BASE_ADDR + ADDR_W'((RING_BURSTS - 1) * BURST_INC);
    localparam logic [CNT_W-1:0]  FILL_MAX  = CNT_W'(RING_BURSTS);
    localparam logic [CNT_W-1:0]  START_TH  = CNT_W'(RD_START_TH);

    // Handshake: a command transfers on a cycle where cmd_valid && cmd_ready; cmd_valid,
    // cmd_rw and cmd_addr stay frozen until then.
    logic [1:0]        state_q, state_d;
    logic              cmd_valid_q, cmd_valid_d;
    logic              cmd_rw_q, cmd_rw_d;
    logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
    logic              wr_ack_q, wr_ack_d;
    logic              rd_ack_q, rd_ack_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  fill_q, fill_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              play_en_q, play_en_d;
    logic              flushed_q, flushed_d;
    logic              last_wr_q, last_wr_d;
    logic              wr_elig, rd_elig, pick_rd, wr_hs, rd_hs;

`ifdef ARB_TIMEOUT_EN
    localparam int               TMO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             timeout_err_q, timeout_err_d;
`endif

    function automatic logic [ADDR_W-1:0] ptr_next(input logic [ADDR_W-1:0] p);
        return (p == LAST_ADDR) ? BASE_ADDR : p + INC;
    endfunction

    always_comb begin
        state_d     = state_q;
        cmd_valid_d = cmd_valid_q;
        cmd_rw_d    = cmd_rw_q;
        cmd_addr_d  = cmd_addr_q;
        wr_ack_d    = 1'b0;
        rd_ack_d    = 1'b0;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        fill_d      = fill_q;
        play_en_d   = play_en_q;
        flushed_d   = flushed_q | flush;
        last_wr_d   = last_wr_q;
        pick_rd     = 1'b0;
`ifdef ARB_TIMEOUT_EN
        tmo_cnt_d     = (state_q == S_WAIT) ? tmo_cnt_q + 1'b1 : '0;
        timeout_err_d = timeout_err_q;
`endif

        wr_elig = wr_req && !full_q;
        rd_elig = rd_req && !empty_q && play_en_q;
        wr_hs   = (state_q == S_CMD) && cmd_ready && !cmd_rw_q;
        rd_hs   = (state_q == S_CMD) && cmd_ready && cmd_rw_q;

        case (state_q)
            S_IDLE: begin
                if (wr_elig || rd_elig) begin
                    // On a tie, read wins only if the previous grant was a write.
                    pick_rd     = rd_elig && (!wr_elig || last_wr_q);
                    state_d     = S_CMD;
                    cmd_valid_d = 1'b1;
                    cmd_rw_d    = pick_rd;
                    cmd_addr_d  = pick_rd ? rd_ptr_q : wr_ptr_q;
                    last_wr_d   = !pick_rd;
                end
            end
            S_CMD: begin
                if (cmd_ready) begin
                    state_d     = S_WAIT;
                    cmd_valid_d = 1'b0;
                    wr_ack_d    = !cmd_rw_q;
                    rd_ack_d    = cmd_rw_q;
                end
            end
            S_WAIT: begin
                if (done) begin
                    state_d = S_IDLE;
                end
`ifdef ARB_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_LAST) begin
                    state_d       = S_IDLE;
                    timeout_err_d = 1'b1;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase

        if (wr_hs) begin
            wr_ptr_d = ptr_next(wr_ptr_q);
            fill_d   = fill_q + 1'b1;
        end else if (rd_hs) begin
            rd_ptr_d = ptr_next(rd_ptr_q);
            fill_d   = fill_q - 1'b1;
        end

        full_d  = (fill_d == FILL_MAX);
        empty_d = (fill_d == '0);

        if (flush || fill_d >= START_TH) begin
            play_en_d = 1'b1;
        end
        // End of stream: the read that drains a flushed ring stops playout, unless a new
        // flush lands on that very cycle.
        if (rd_hs && fill_q == CNT_W'(1) && flushed_q && !flush) begin
            play_en_d = 1'b0;
            flushed_d = 1'b0;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= S_IDLE;
            cmd_valid_q <= 1'b0;
            cmd_rw_q    <= 1'b0;
            cmd_addr_q  <= BASE_ADDR;
            wr_ack_q    <= 1'b0;
            rd_ack_q    <= 1'b0;
            wr_ptr_q    <= BASE_ADDR;
            rd_ptr_q    <= BASE_ADDR;
            fill_q      <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            play_en_q   <= 1'b0;
            flushed_q   <= 1'b0;
            last_wr_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_rw_q    <= cmd_rw_d;
            cmd_addr_q  <= cmd_addr_d;
            wr_ack_q    <= wr_ack_d;
            rd_ack_q    <= rd_ack_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fill_q      <= fill_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            play_en_q   <= play_en_d;
            flushed_q   <= flushed_d;
            last_wr_q   <= last_wr_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tmo_cnt_q     <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            tmo_cnt_q     <= tmo_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end
    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign cmd_valid   = cmd_valid_q;
    assign cmd_rw      = cmd_rw_q;
    assign cmd_addr    = cmd_addr_q;
    assign wr_ack      = wr_ack_q;
    assign rd_ack      = rd_ack_q;
    assign fill        = fill_q;
    assign full        = full_q;
    assign empty       = empty_q;
    assign play_en     = play_en_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ddr3_burst_arbiter.sv
// Directed bench for ddr3_burst_arbiter: a per-cycle vector table plus multi-cycle sequences.
// Build with ARB_TIMEOUT_EN defined to exercise the watchdog expectations.
module tb_ddr3_burst_arbiter;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CMD  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        wr_req = 1'b0, rd_req = 1'b0, flush = 1'b0, cmd_ready = 1'b0, done = 1'b0;
    logic        cmd_valid, cmd_rw, wr_ack, rd_ack, full, empty, play_en, timeout_err;
    logic [27:0] cmd_addr;
    logic [10:0] fill;
    logic [1:0]  dbg_state;

    int n_cmp = 0;
    int n_bad = 0;
    logic [27:0] exp_q[$];

    ddr3_burst_arbiter dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .wr_req(wr_req), .rd_req(rd_req),
        .flush(flush), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
        .cmd_addr(cmd_addr), .done(done), .wr_ack(wr_ack), .rd_ack(rd_ack), .fill(fill),
        .full(full), .empty(empty), .play_en(play_en), .timeout_err(timeout_err),
        .dbg_state_o(dbg_state)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "bench watchdog expired");
    end

    typedef struct {
        logic wr, rd, fl, rdy, dn;
        logic vld, rw;
        logic [27:0] addr;
        logic wa, ra;
        logic [10:0] fill;
        logic emp, pe;
        logic [1:0] st;
    } vec_t;

    vec_t vt[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: event did not occur within its cycle budget", name);
    endtask

    task automatic tick;
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_reset;
        wr_req = 1'b0; rd_req = 1'b0; flush = 1'b0; cmd_ready = 1'b0; done = 1'b0;
        sys_rst_n = 1'b0;
        repeat (2) tick;
        sys_rst_n = 1'b1;
        tick;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_state"}, dbg_state, ST_IDLE);
        check({tag, "_cmd_valid"}, cmd_valid, 1'b0);
        check({tag, "_cmd_rw"}, cmd_rw, 1'b0);
        check({tag, "_cmd_addr"}, cmd_addr, 28'h0);
        check({tag, "_acks"}, {wr_ack, rd_ack}, 2'b00);
        check({tag, "_fill"}, fill, 11'd0);
        check({tag, "_full"}, full, 1'b0);
        check({tag, "_empty"}, empty, 1'b1);
        check({tag, "_play_en"}, play_en, 1'b0);
        check({tag, "_timeout_err"}, timeout_err, 1'b0);
    endtask

    // Wait for a command, hold cmd_ready low for 'hold' cycles, handshake, then done 4 cycles later.
    task automatic serve(input int hold, input logic flush_hs, output logic rw, output logic [27:0] addr);
        int n;
        rw = 1'b0;
        addr = '0;
        n = 0;
        while (!cmd_valid && n < 40) begin
            tick;
            n++;
        end
        if (!cmd_valid) begin
            fail_now("cmd_valid_wait");
        end else begin
            rw = cmd_rw;
            addr = cmd_addr;
            for (int i = 0; i < hold; i++) begin
                tick;
                check("hold_valid", cmd_valid, 1'b1);
                check("hold_addr", cmd_addr, addr);
                check("hold_rw", cmd_rw, rw);
                check("hold_no_ack", wr_ack | rd_ack, 1'b0);
            end
            cmd_ready = 1'b1;
            flush = flush_hs;
            tick;
            cmd_ready = 1'b0;
            flush = 1'b0;
            check("ack_wr", wr_ack, !rw);
            check("ack_rd", rd_ack, rw);
            check("valid_drop", cmd_valid, 1'b0);
            tick;
            check("ack_single", wr_ack | rd_ack, 1'b0);
            repeat (2) tick;
            done = 1'b1;
            tick;
            done = 1'b0;
            check("back_idle", dbg_state, ST_IDLE);
        end
    endtask

    initial begin
        logic        rw;
        logic [27:0] addr;
        int          n;
        logic        seen;

        //      wr    rd    fl    rdy   dn    vld   rw    addr     wa    ra    fill     emp   pe    st
        vt[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 28'd0, 1'b0, 1'b0, 11'd0, 1'b1, 1'b0, ST_CMD};
        vt[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 28'd0, 1'b0, 1'b0, 11'd0, 1'b1, 1'b0, ST_CMD};
        vt[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 28'd0, 1'b1, 1'b0, 11'd1, 1'b0, 1'b0, ST_WAIT};
        vt[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 28'd0, 1'b0, 1'b0, 11'd1, 1'b0, 1'b0, ST_WAIT};
        vt[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 28'd0, 1'b0, 1'b0, 11'd1, 1'b0, 1'b0, ST_IDLE};
        vt[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 28'd0, 1'b0, 1'b0, 11'd1, 1'b0, 1'b0, ST_IDLE};
        vt[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 28'd8, 1'b0, 1'b0, 11'd1, 1'b0, 1'b0, ST_CMD};
        vt[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 28'd8, 1'b1, 1'b0, 11'd2, 1'b0, 1'b0, ST_WAIT};
        vt[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 28'd8, 1'b0, 1'b0, 11'd2, 1'b0, 1'b0, ST_IDLE};
        vt[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 28'd8, 1'b0, 1'b0, 11'd2, 1'b0, 1'b0, ST_IDLE};
        vt[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 28'd8, 1'b0, 1'b0, 11'd2, 1'b0, 1'b1, ST_IDLE};
        vt[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 28'd0, 1'b0, 1'b0, 11'd2, 1'b0, 1'b1, ST_CMD};
        vt[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 28'd0, 1'b0, 1'b1, 11'd1, 1'b0, 1'b1, ST_WAIT};
        vt[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 28'd0, 1'b0, 1'b0, 11'd1, 1'b0, 1'b1, ST_IDLE};

        // Reset state
        do_reset;
        check_reset_vals("reset");

        // Per-cycle vector table
        for (int i = 0; i < 14; i++) begin
            wr_req = vt[i].wr; rd_req = vt[i].rd; flush = vt[i].fl;
            cmd_ready = vt[i].rdy; done = vt[i].dn;
            tick;
            check($sformatf("vec%0d_valid", i), cmd_valid, vt[i].vld);
            check($sformatf("vec%0d_rw", i), cmd_rw, vt[i].rw);
            check($sformatf("vec%0d_addr", i), cmd_addr, vt[i].addr);
            check($sformatf("vec%0d_wr_ack", i), wr_ack, vt[i].wa);
            check($sformatf("vec%0d_rd_ack", i), rd_ack, vt[i].ra);
            check($sformatf("vec%0d_fill", i), fill, vt[i].fill);
            check($sformatf("vec%0d_empty", i), empty, vt[i].emp);
            check($sformatf("vec%0d_play_en", i), play_en, vt[i].pe);
            check($sformatf("vec%0d_state", i), dbg_state, vt[i].st);
        end
        wr_req = 1'b0; rd_req = 1'b0; flush = 1'b0; cmd_ready = 1'b0; done = 1'b0;

        // Startup fill to the playout threshold, read requested throughout
        do_reset;
        for (int i = 0; i < 1024; i++) exp_q.push_back(28'(i * 8));
        wr_req = 1'b1; rd_req = 1'b1;
        for (int i = 0; i < 512; i++) begin
            check("no_early_play", play_en, 1'b0);
            serve(0, 1'b0, rw, addr);
            check("startup_is_write", rw, 1'b0);
            check("startup_addr", addr, exp_q.pop_front());
        end
        rd_req = 1'b0;
        check("fill_at_th", fill, 11'd512);
        check("play_at_th", play_en, 1'b1);

        // Fill to capacity, then the ring refuses further writes
        for (int i = 512; i < 1024; i++) begin
            serve(0, 1'b0, rw, addr);
            check("fill_is_write", rw, 1'b0);
            check("fill_addr", addr, exp_q.pop_front());
        end
        check("full_flag", full, 1'b1);
        check("full_fill", fill, 11'd1024);
        seen = 1'b0;
        repeat (30) begin
            tick;
            seen = seen | cmd_valid;
        end
        check("no_write_when_full", seen, 1'b0);
        wr_req = 1'b0; rd_req = 1'b1;
        serve(0, 1'b0, rw, addr);
        check("first_read_rw", rw, 1'b1);
        check("first_read_addr", addr, 28'd0);
        check("not_full_after_read", full, 1'b0);
        wr_req = 1'b1; rd_req = 1'b0;
        serve(0, 1'b0, rw, addr);
        check("wrap_write_rw", rw, 1'b0);
        check("wrap_write_addr", addr, 28'd0);
        check("full_again", full, 1'b1);

        // Drain to 600 then alternate under contention
        wr_req = 1'b0; rd_req = 1'b1;
        for (int i = 1; i <= 424; i++) begin
            serve(0, 1'b0, rw, addr);
            check("drain_rw", rw, 1'b1);
            check("drain_addr", addr, 28'(i * 8));
        end
        check("drain_fill", fill, 11'd600);
        wr_req = 1'b1; rd_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            serve(0, 1'b0, rw, addr);
            check("alt_rw", rw, (k % 2 == 1));
            check("alt_addr", addr, (k % 2 == 0) ? 28'(8 + 8 * (k / 2)) : 28'(3400 + 8 * (k / 2)));
            check("alt_fill_band", (fill == 11'd600) || (fill == 11'd601), 1'b1);
        end
        wr_req = 1'b0; rd_req = 1'b0;

        // Stalled handshake, then flush drains a short stream
        do_reset;
        wr_req = 1'b1;
        serve(5, 1'b0, rw, addr);
        check("stall_addr", addr, 28'd0);
        serve(0, 1'b0, rw, addr);
        serve(0, 1'b0, rw, addr);
        wr_req = 1'b0;
        check("short_fill", fill, 11'd3);
        check("short_no_play", play_en, 1'b0);
        flush = 1'b1;
        tick;
        flush = 1'b0;
        check("flush_play", play_en, 1'b1);
        rd_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            serve(0, 1'b0, rw, addr);
            check("flush_read_rw", rw, 1'b1);
            check("flush_read_addr", addr, 28'(i * 8));
        end
        rd_req = 1'b0;
        check("drained_play", play_en, 1'b0);
        check("drained_empty", empty, 1'b1);
        check("drained_fill", fill, 11'd0);

        // Flush coinciding with the emptying read keeps playout on
        do_reset;
        wr_req = 1'b1;
        serve(0, 1'b0, rw, addr);
        wr_req = 1'b0;
        flush = 1'b1;
        tick;
        flush = 1'b0;
        rd_req = 1'b1;
        serve(0, 1'b1, rw, addr);
        check("coflush_rw", rw, 1'b1);
        check("coflush_play", play_en, 1'b1);
        check("coflush_empty", empty, 1'b1);
        rd_req = 1'b0; wr_req = 1'b1;
        serve(0, 1'b0, rw, addr);
        check("coflush_write_addr", addr, 28'd8);
        wr_req = 1'b0; rd_req = 1'b1;
        serve(0, 1'b0, rw, addr);
        check("coflush_read2_rw", rw, 1'b1);
        check("coflush_read2_addr", addr, 28'd8);
        check("coflush_end_play", play_en, 1'b0);
        rd_req = 1'b0;

        // Reset while a command is pending: burst abandoned, no ack
        do_reset;
        wr_req = 1'b1;
        tick;
        wr_req = 1'b0;
        check("pend_cmd_state", dbg_state, ST_CMD);
        #2 sys_rst_n = 1'b0;
        #1 check_reset_vals("rst_cmd");
        tick;
        sys_rst_n = 1'b1;
        seen = 1'b0;
        repeat (5) begin
            tick;
            seen = seen | wr_ack | rd_ack | cmd_valid;
        end
        check("rst_cmd_no_ack", seen, 1'b0);

        // Completion withheld
        do_reset;
        wr_req = 1'b1;
        tick;
        wr_req = 1'b0;
        cmd_ready = 1'b1;
        tick;
        cmd_ready = 1'b0;
        check("wd_in_wait", dbg_state, ST_WAIT);
`ifdef ARB_TIMEOUT_EN
        n = 0;
        while (dbg_state != ST_IDLE && n < 1100) begin
            tick;
            n++;
        end
        check("wd_wait_cycles", n, 1024);
        check("wd_timeout_err", timeout_err, 1'b1);
        check("wd_fill_kept", fill, 11'd1);
        repeat (3) tick;
        check("wd_err_sticky", timeout_err, 1'b1);
`else
        n = 0;
        repeat (1100) begin
            tick;
            n++;
        end
        check("nowd_still_wait", dbg_state, ST_WAIT);
        check("nowd_no_err", timeout_err, 1'b0);
        check("nowd_fill", fill, 11'd1);
`endif
        // Reset asserted mid-WAIT
        wr_req = 1'b1;
        n = 0;
        while (dbg_state != ST_WAIT && n < 1200) begin
            if (dbg_state == ST_CMD) cmd_ready = 1'b1;
            tick;
            cmd_ready = 1'b0;
            n++;
        end
        wr_req = 1'b0;
        if (dbg_state != ST_WAIT) fail_now("reach_wait");
        #2 sys_rst_n = 1'b0;
        #1 check_reset_vals("rst_wait");
        tick;
        sys_rst_n = 1'b1;
        tick;
        check_reset_vals("post_rst_wait");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ddr3_burst_arbiter.md
DDR3_BURST_ARBITER -- requirements
Module: ddr3_burst_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 28, DDR command address width.
REQ-002 SHALL have parameter BASE_ADDR, default 0, ring base address.
REQ-003 SHALL have parameter BURST_INC, default 8, address step per burst (BL8 x16).
REQ-004 SHALL have parameter RING_BURSTS, default 1024, ring capacity in bursts.
REQ-005 SHALL have parameter CNT_W, default 11, fill counter width (holds 0..RING_BURSTS).
REQ-006 SHALL have parameter RD_START_TH, default 512, fill level that enables playout.
REQ-007 SHALL have parameter TIMEOUT_CYC, default 1024, completion watchdog limit.
REQ-008 SHALL have port sys_clk, input, 1, sole clock.
REQ-009 SHALL have port sys_rst_n, input, 1, asynchronous active-low reset.
REQ-010 SHALL have port wr_req, input, 1, ingress FIFO holds at least one burst.
REQ-011 SHALL have port rd_req, input, 1, egress FIFO has room for one burst.
REQ-012 SHALL have port flush, input, 1, single-cycle end-of-stream pulse (rxEnd).
REQ-013 SHALL have ports cmd_valid (output, 1), cmd_ready (input, 1), cmd_rw (output, 1; 0 = write, 1 = read), cmd_addr (output, ADDR_W); this is the controller command handshake.
REQ-014 SHALL have port done, input, 1, burst-complete pulse from the DDR controller.
REQ-015 SHALL have ports wr_ack and rd_ack, output, 1 each, burst-granted pulses.
REQ-016 SHALL have ports fill (output, CNT_W), full (output, 1), empty (output, 1), play_en (output, 1), timeout_err (output, 1).

Function
REQ-017 SHALL implement FSM IDLE -> CMD -> WAIT -> IDLE with one outstanding burst.
REQ-018 SHALL treat write as eligible when wr_req && !full, and read as eligible when rd_req && !empty && play_en.
REQ-019 IDLE SHALL select a requester on the cycle eligibility is sampled, with cmd_valid asserting on the next cycle.
REQ-020 When both are eligible, selection SHALL alternate against the last grant; the first tie after reset SHALL go to write.
REQ-021 In CMD, cmd_valid, cmd_rw and cmd_addr SHALL be held stable until cmd_ready; the FSM SHALL then enter WAIT.
REQ-022 wr_ack or rd_ack SHALL pulse exactly one cycle, the cycle after the cmd handshake.
REQ-023 In WAIT, done SHALL return the FSM to IDLE; done outside WAIT SHALL be ignored.
REQ-024 Write and read pointers SHALL each advance by BURST_INC on their handshake and wrap from BASE_ADDR+(RING_BURSTS-1)*BURST_INC to BASE_ADDR.
REQ-025 fill SHALL increment on a write handshake and decrement on a read handshake; both cannot occur in the same cycle.
REQ-026 full SHALL equal (fill==RING_BURSTS) and empty SHALL equal (fill==0), both registered with fill.
REQ-027 play_en SHALL set when fill>=RD_START_TH or when flush is seen.
REQ-028 flush SHALL set a sticky flushed flag; when fill reaches 0 with flushed set, play_en and flushed SHALL both clear on the same edge.
REQ-029 flush arriving in the same cycle as the read handshake that empties the ring SHALL keep play_en set.

Reset
REQ-030 Asynchronous assertion of sys_rst_n SHALL force IDLE, with cmd_valid=0, cmd_rw=0, cmd_addr=BASE_ADDR, wr_ack=rd_ack=0, fill=0, full=0, empty=1, play_en=0, timeout_err=0, both pointers=BASE_ADDR, and the next tie going to write.
REQ-031 Reset during CMD or WAIT SHALL abandon the burst without issuing an ack; release SHALL be synchronous to sys_clk.

Configuration
REQ-032 With macro ARB_TIMEOUT_EN defined, a counter SHALL run in WAIT; reaching TIMEOUT_CYC cycles without done SHALL return the FSM to IDLE and set sticky timeout_err, which clears only on reset, and pointers and fill SHALL keep their handshake values.
REQ-033 Without ARB_TIMEOUT_EN, WAIT SHALL last indefinitely until done, and timeout_err SHALL be tied 0.

Verification
REQ-034 Stimulus: wr_req=1, rd_req=0, cmd_ready=1, done 4 cycles after each cmd. Required: 512 writes at addresses 0, 8, ..., 4088; play_en rises when fill=512; no read is issued before that.
REQ-035 Stimulus: fill=600, wr_req=rd_req=1. Required: grants alternate W,R,W,R; fill stays at 600±1.
REQ-036 Stimulus: 1024 writes, then wr_req still 1. Required: full=1 and no further write cmd; the 1025th write goes to address 0 after one read.
REQ-037 Stimulus: fill=3, play_en=0, flush pulse, rd_req=1. Required: 3 reads, then play_en=0, empty=1.
REQ-038 Stimulus: cmd_ready held low 5 cycles. Required: cmd_valid/cmd_addr stable for all 5 cycles; a single ack follows the handshake.
REQ-039 Stimulus: with ARB_TIMEOUT_EN, done withheld. Required: timeout_err=1 after 1024 WAIT cycles and the FSM back in IDLE; reset asserted mid-WAIT gives all REQ-030 values.
